// File: rtl/interruption_if.sv
// Interruption source interface: stop request levels in, framed code/valid out.
interface interruption_if;
   logic [2:0] req;
   logic       resend;
   logic [2:0] o_code;
   logic       o_valid;
   logic       o_busy;
   logic       o_done;

   // Control side drives requests and observes the framed code.
   modport master (output req, resend, input o_code, o_valid, o_busy, o_done);
   // Encoder side.
   modport slave  (input req, resend, output o_code, o_valid, o_busy, o_done);
endinterface

// File: rtl/interruption_encoder.sv
// Interruption encoder: turns stop request levels into a 3-bit code framed as
// SETUP -> HOLD -> GAP so a mux synchronizer on the far side samples a stable code.
module interruption_encoder #(
   parameter int SETUP_CYC = 1,
   parameter int HOLD_CYC  = 4,
   parameter int GAP_CYC   = 2
) (
   input logic           clk,
   input logic           rst_n,
   interruption_if.slave bus
);
   localparam int MAX_SH = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int MAX_P  = (MAX_SH > GAP_CYC) ? MAX_SH : GAP_CYC;
   localparam int CW     = $clog2(MAX_P + 1);

   typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    code_q, code_d;
   logic [2:0]    last_q, last_d;
   logic          valid_q, valid_d;

   // Bijective stop-set to code mapping; all eight inputs are listed.
   function automatic logic [2:0] enc(input logic [2:0] r);
      enc = 3'd0;
      case (r)
         3'b000: enc = 3'd0;
         3'b010: enc = 3'd1;
         3'b001: enc = 3'd2;
         3'b110: enc = 3'd3;
         3'b101: enc = 3'd4;
         3'b011: enc = 3'd5;
         3'b100: enc = 3'd6;
         3'b111: enc = 3'd7;
      endcase
   endfunction

   // Next-state: start frames from IDLE, then count through each phase.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      last_d  = last_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            // Requests that changed while busy are picked up here; glitches
            // that settled back to last_q never start a frame.
            if ((bus.req != last_q) || bus.resend) begin
               code_d  = enc(bus.req);
               last_d  = bus.req;
               cnt_d   = CW'(SETUP_CYC - 1);
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = CW'(HOLD_CYC - 1);
               valid_d = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               cnt_d   = CW'(GAP_CYC - 1);
               valid_d = 1'b0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any frame and returns the code to "no stops".
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         code_q  <= 3'd0;
         last_q  <= 3'b000;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   assign bus.o_code  = code_q;
   assign bus.o_valid = valid_q;
   assign bus.o_busy  = (state_q != IDLE);
   // Done marks the final GAP cycle, i.e. the one leading into IDLE.
   assign bus.o_done  = (state_q == GAP) && (cnt_q == '0);
endmodule

// File: tb/tb_interruption_encoder.sv
// Directed bench for interruption_encoder with default frame parameters.
module tb_interruption_encoder;
   localparam int HOLD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   interruption_if bus();

   interruption_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   // Expected code table and the receiver's inverse of it.
   function automatic int exp_code(input logic [2:0] r);
      case (r)
         3'b000: return 0; 3'b010: return 1; 3'b001: return 2; 3'b110: return 3;
         3'b101: return 4; 3'b011: return 5; 3'b100: return 6; default: return 7;
      endcase
   endfunction

   function automatic logic [2:0] mgr_decode(input logic [2:0] c);
      case (c)
         3'd0: return 3'b000; 3'd1: return 3'b010; 3'd2: return 3'b001; 3'd3: return 3'b110;
         3'd4: return 3'b101; 3'd5: return 3'b011; 3'd6: return 3'b100; default: return 3'b111;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Advance until o_done (bounded), then step into IDLE.
   task automatic wait_done(input string tag);
      for (int i = 0; i < 30 && !bus.o_done; i++) tick();
      chk(tag, int'(bus.o_done), 1);
      tick();
   endtask

   // Receiver model plus frame-property monitor.
   logic       rst_seen = 1'b0;
   logic       mon_en = 1'b0;
   logic       prev_ok = 1'b0;
   logic       prev_busy = 1'b0;
   logic [2:0] prev_code = '0;
   logic [2:0] mgr_req = '0;
   int         vrun = 0;

   always @(posedge clk) rst_seen <= rst_n;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_seen && prev_ok && prev_busy) chk("code_stable", bus.o_code, prev_code);
         if (!rst_seen) vrun = 0;
         else if (bus.o_valid) begin
            vrun++;
            mgr_req = mgr_decode(bus.o_code);
         end else if (vrun != 0) begin
            chk("valid_run", vrun, HOLD);
            vrun = 0;
         end
         prev_busy = bus.o_busy;
         prev_code = bus.o_code;
         prev_ok   = rst_seen;
      end
   end

   logic [2:0] sweep [8] = '{3'b001, 3'b110, 3'b101, 3'b011, 3'b100, 3'b111, 3'b000, 3'b010};
   logic       t2_valid [7] = '{0, 1, 1, 1, 1, 0, 0};
   logic       t2_done  [7] = '{0, 0, 0, 0, 0, 0, 1};

   initial begin
      bus.req = 3'b111;
      bus.resend = 1'b0;
      // T1 reset
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_code", bus.o_code, 0);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
      rst_n = 1'b1;
      bus.req = 3'b000;
      mon_en = 1'b1;
      repeat (3) tick();
      chk("post_rst_busy", bus.o_busy, 0);
      chk("post_rst_code", bus.o_code, 0);

      // T2 single frame with exact cadence
      bus.req = 3'b010;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("t2_code", bus.o_code, 1);
         chk("t2_busy", bus.o_busy, 1);
         chk("t2_valid", bus.o_valid, int'(t2_valid[i]));
         chk("t2_done", bus.o_done, int'(t2_done[i]));
      end
      tick();
      chk("t2_idle_busy", bus.o_busy, 0);
      chk("t2_idle_done", bus.o_done, 0);

      // T3 encode sweep, decoded back by the receiver model
      foreach (sweep[k]) begin
         bus.req = sweep[k];
         tick();
         chk("t3_code", bus.o_code, exp_code(sweep[k]));
         wait_done("t3_done");
         chk("t3_mgr", mgr_req, sweep[k]);
      end

      // T4 change during HOLD is sent only after the frame
      bus.req = 3'b110;
      tick(); tick();
      bus.req = 3'b101;
      tick(); tick();
      chk("t4_hold_code", bus.o_code, 3);
      wait_done("t4_done1");
      chk("t4_idle_busy", bus.o_busy, 0);
      chk("t4_idle_code", bus.o_code, 3);
      tick();
      chk("t4_second_code", bus.o_code, 4);
      wait_done("t4_done2");
      // glitch returning to the sent value inside HOLD
      bus.req = 3'b110;
      tick(); tick();
      bus.req = 3'b011;
      tick();
      bus.req = 3'b110;
      tick();
      wait_done("t4_done3");
      tick(); tick();
      chk("t4_glitch_busy", bus.o_busy, 0);
      chk("t4_glitch_code", bus.o_code, 3);

      // T5 resend in IDLE reframes; resend in GAP is ignored
      bus.req = 3'b101;
      tick();
      wait_done("t5_done0");
      tick();
      chk("t5_quiet", bus.o_busy, 0);
      bus.resend = 1'b1;
      tick();
      bus.resend = 1'b0;
      chk("t5_resend_busy", bus.o_busy, 1);
      chk("t5_resend_code", bus.o_code, 4);
      repeat (5) tick();
      chk("t5_in_gap", bus.o_valid, 0);
      bus.resend = 1'b1;
      tick();
      bus.resend = 1'b0;
      chk("t5_done", bus.o_done, 1);
      repeat (3) tick();
      chk("t5_gap_ignored", bus.o_busy, 0);

      // T6 reset during HOLD aborts; the held request is resent afterwards
      bus.resend = 1'b1;
      tick();
      bus.resend = 1'b0;
      tick(); tick();
      chk("t6_in_hold", bus.o_valid, 1);
      rst_n = 1'b0;
      tick();
      chk("t6_rst_valid", bus.o_valid, 0);
      chk("t6_rst_code", bus.o_code, 0);
      chk("t6_rst_busy", bus.o_busy, 0);
      rst_n = 1'b1;
      tick();
      chk("t6_new_code", bus.o_code, 4);
      chk("t6_new_busy", bus.o_busy, 1);
      wait_done("t6_done");
      chk("t6_mgr", mgr_req, 3'b101);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
